// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared definitions for the rv32i pipeline control unit: FSM encodings and RAW match helper.
package rv_pipe_ctrl_pkg;

  localparam logic [1:0] PC_RUN   = 2'd0;
  localparam logic [1:0] PC_HAZ   = 2'd1;
  localparam logic [1:0] PC_MEMW  = 2'd2;
  localparam logic [1:0] PC_REDIR = 2'd3;

  localparam int unsigned FLUSH_CNT_W = 4;

  // Source operand read in decode collides with a pending write; x0 never collides.
  function automatic logic raw_match(input logic       use_src,
                                     input logic [4:0] src_addr,
                                     input logic       stage_ce,
                                     input logic       stage_wr_en,
                                     input logic [4:0] rd_addr);
    return use_src & stage_ce & stage_wr_en & (rd_addr != 5'd0) & (rd_addr == src_addr);
  endfunction

endpackage

// File: rtl/rv_hazard_unit.sv
// Combinational RAW hazard detector for decode operands.
// RV_FORWARD_EN: EX->ID bypass present, only load-use against EX stalls.
module rv_hazard_unit (
  input  logic       id_ce,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       ex_ce,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_wr_en,
  input  logic       ex_is_load,
  input  logic       mem_ce,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_wr_en,
  output logic       hazard
);
  import rv_pipe_ctrl_pkg::*;

  logic ex_hit;

  assign ex_hit = raw_match(use_rs1, rs1_addr, ex_ce, ex_wr_en, ex_rd_addr) |
                  raw_match(use_rs2, rs2_addr, ex_ce, ex_wr_en, ex_rd_addr);

`ifdef RV_FORWARD_EN
  logic unused_mem;

  assign hazard     = id_ce & ex_is_load & ex_hit;
  assign unused_mem = ^{mem_ce, mem_rd_addr, mem_wr_en};
`else
  logic mem_hit;
  logic unused_load;

  assign mem_hit = raw_match(use_rs1, rs1_addr, mem_ce, mem_wr_en, mem_rd_addr) |
                   raw_match(use_rs2, rs2_addr, mem_ce, mem_wr_en, mem_rd_addr);
  assign hazard      = id_ce & (ex_hit | mem_hit);
  assign unused_load = ex_is_load;
`endif

endmodule

// File: rtl/rv_pipe_ctrl.sv
// rv32i pipeline control: stall/flush/redirect generation plus saturating stall-cycle counter.
// Hazard rules change with the RV_FORWARD_EN macro (see rv_hazard_unit).
module rv_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_id_ce,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_ce,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_wr_en,
  input  logic             i_ex_is_load,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_ce,
  input  logic [4:0]       i_mem_rd_addr,
  input  logic             i_mem_wr_en,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_redirect,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles
);
  import rv_pipe_ctrl_pkg::*;

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   resume_redir_q, resume_redir_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic hazard, memwait, branch;
  logic stall_if, stall_id, flush_id, flush_ex, redirect;

  rv_hazard_unit u_hazard (
    .id_ce       (i_id_ce),
    .rs1_addr    (i_id_rs1_addr),
    .rs2_addr    (i_id_rs2_addr),
    .use_rs1     (i_id_use_rs1),
    .use_rs2     (i_id_use_rs2),
    .ex_ce       (i_ex_ce),
    .ex_rd_addr  (i_ex_rd_addr),
    .ex_wr_en    (i_ex_wr_en),
    .ex_is_load  (i_ex_is_load),
    .mem_ce      (i_mem_ce),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_wr_en   (i_mem_wr_en),
    .hazard      (hazard)
  );

  assign memwait = i_dmem_req & ~i_dmem_ack;
  assign branch  = i_ex_ce & i_ex_branch_taken;

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    resume_redir_d = resume_redir_q;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    redirect       = 1'b0;

    if (memwait) begin
      // Freeze everything; remember whether a redirect window was interrupted.
      stall_if = 1'b1;
      stall_id = 1'b1;
      state_d  = PC_MEMW;
      if (state_q != PC_MEMW) begin
        resume_redir_d = (state_q == PC_REDIR);
      end
    end else begin
      case (state_q)
        PC_RUN, PC_HAZ: begin
          if (branch) begin
            redirect = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
            fcnt_d   = FLUSH_LOAD;
            state_d  = (FLUSH_LOAD == '0) ? PC_RUN : PC_REDIR;
          end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = PC_HAZ;
          end else begin
            state_d = PC_RUN;
          end
        end
        PC_REDIR: begin
          flush_id = 1'b1;
          if (fcnt_q <= FLUSH_CNT_W'(1)) begin
            fcnt_d  = '0;
            state_d = PC_RUN;
          end else begin
            fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          // Access completed this cycle: pipe advances, then the saved mode resumes.
          state_d = resume_redir_q ? PC_REDIR : PC_RUN;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PC_RUN;
      fcnt_q         <= '0;
      resume_redir_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      resume_redir_q <= resume_redir_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign o_stall_if     = ~reset & stall_if;
  assign o_stall_id     = ~reset & stall_id;
  assign o_flush_id     = ~reset & flush_id;
  assign o_flush_ex     = ~reset & flush_ex;
  assign o_redirect     = ~reset & redirect;
  assign o_state        = reset ? PC_RUN : state_q;
  assign o_stall_cycles = reset ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Self-checking bench for rv_pipe_ctrl: directed scenarios plus randomized run against a
// cycle-level reference model.
module tb_rv_pipe_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;
`ifdef RV_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             id_ce, use_rs1, use_rs2;
  logic [4:0]       rs1, rs2, ex_rd, mem_rd;
  logic             ex_ce, ex_wr, ex_load, ex_br, mem_ce, mem_wr, dreq, dack;
  logic             stall_if, stall_id, flush_id, flush_ex, redirect;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [4:0]       outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_id_ce           (id_ce),
    .i_id_rs1_addr     (rs1),
    .i_id_rs2_addr     (rs2),
    .i_id_use_rs1      (use_rs1),
    .i_id_use_rs2      (use_rs2),
    .i_ex_ce           (ex_ce),
    .i_ex_rd_addr      (ex_rd),
    .i_ex_wr_en        (ex_wr),
    .i_ex_is_load      (ex_load),
    .i_ex_branch_taken (ex_br),
    .i_mem_ce          (mem_ce),
    .i_mem_rd_addr     (mem_rd),
    .i_mem_wr_en       (mem_wr),
    .i_dmem_req        (dreq),
    .i_dmem_ack        (dack),
    .o_stall_if        (stall_if),
    .o_stall_id        (stall_id),
    .o_flush_id        (flush_id),
    .o_flush_ex        (flush_ex),
    .o_redirect        (redirect),
    .o_state           (state),
    .o_stall_cycles    (stall_cycles)
  );

  // {stall_if, stall_id, flush_id, flush_ex, redirect}
  assign outs = {stall_if, stall_id, flush_id, flush_ex, redirect};

  task automatic set_idle();
    reset = 1'b0; id_ce = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; rs1 = '0; rs2 = '0;
    ex_ce = 1'b0; ex_rd = '0; ex_wr = 1'b0; ex_load = 1'b0; ex_br = 1'b0;
    mem_ce = 1'b0; mem_rd = '0; mem_wr = 1'b0; dreq = 1'b0; dack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference hazard: any valid writer stage whose nonzero rd equals a used source.
  function automatic bit model_hazard();
    bit hz = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bit       writes = (s == 0) ? (ex_ce && ex_wr) : (mem_ce && mem_wr);
      bit [4:0] rd     = (s == 0) ? ex_rd : mem_rd;
      if (FWD && (s == 1 || !ex_load)) writes = 1'b0;
      if (writes && rd != 0 && ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd))) hz = 1'b1;
    end
    return id_ce && hz;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1; id_ce = 1'b1; use_rs1 = 1'b1; rs1 = 5'd4;
    ex_ce = 1'b1; ex_wr = 1'b1; ex_load = 1'b1; ex_rd = 5'd4; ex_br = 1'b1; dreq = 1'b1;
    #1;
    n_tests++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 5'b0);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_tests++;
    if (state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_tests++;
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] exp_o [4];
    logic [1:0] exp_s [4];
    exp_o = '{5'b11010, FWD ? 5'b0 : 5'b11010, 5'b0, 5'b0};
    exp_s = '{2'd0, 2'd1, FWD ? 2'd0 : 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      id_ce = 1'b1; use_rs1 = 1'b1; rs1 = 5'd5;
      ex_ce = (c == 0); ex_rd = 5'd5; ex_wr = 1'b1; ex_load = 1'b1;
      mem_ce = (c == 1); mem_rd = 5'd5; mem_wr = 1'b1;
      #1;
      n_tests++;
      if (outs !== exp_o[c] || state !== exp_s[c]) begin
        n_fail++;
        $display("FAIL load_use c%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 c, outs, state, exp_o[c], exp_s[c]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (stall_cycles !== (FWD ? 4'd1 : 4'd2)) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cycles, FWD ? 1 : 2);
    end
  endtask

  task automatic test_raw_rs2();
    logic [4:0] exp_o [4];
    logic [1:0] exp_s [4];
    exp_o = '{FWD ? 5'b0 : 5'b11010, FWD ? 5'b0 : 5'b11010, 5'b0, 5'b0};
    exp_s = '{2'd0, FWD ? 2'd0 : 2'd1, FWD ? 2'd0 : 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      id_ce = 1'b1; use_rs2 = 1'b1; rs2 = 5'd3;
      ex_ce = (c == 0); ex_rd = 5'd3; ex_wr = 1'b1;
      mem_ce = (c == 1); mem_rd = 5'd3; mem_wr = 1'b1;
      #1;
      n_tests++;
      if (outs !== exp_o[c] || state !== exp_s[c]) begin
        n_fail++;
        $display("FAIL raw_rs2 c%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 c, outs, state, exp_o[c], exp_s[c]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (stall_cycles !== (FWD ? 4'd0 : 4'd2)) begin
      n_fail++; $display("FAIL raw_rs2_cnt: got %0d expected %0d", stall_cycles, FWD ? 0 : 2);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    id_ce = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
    ex_ce = 1'b1; ex_wr = 1'b1; ex_load = 1'b1; mem_ce = 1'b1; mem_wr = 1'b1;
    #1;
    n_tests++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL x0_match: got %b expected %b", outs, 5'b0);
    end
    @(negedge clk);
    id_ce = 1'b0; rs1 = 5'd7; rs2 = 5'd7; ex_rd = 5'd7; mem_rd = 5'd7;
    #1;
    n_tests++;
    if (outs !== 5'b0 || state !== 2'd0) begin
      n_fail++; $display("FAIL id_invalid: got outs=%b state=%0d expected 0 0", outs, state);
    end
  endtask

  task automatic test_branch();
    logic [4:0] exp_o [3];
    logic [1:0] exp_s [3];
    exp_o = '{5'b00111, 5'b00100, 5'b0};
    exp_s = '{2'd0, 2'd3, 2'd0};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      // A pending load-use hazard and a MEM match must not disturb the redirect.
      id_ce = 1'b1; use_rs1 = 1'b1; rs1 = 5'd5;
      ex_ce = (c == 0); ex_br = (c == 0); ex_rd = 5'd5; ex_wr = 1'b1; ex_load = 1'b1;
      mem_ce = (c == 1); mem_rd = 5'd5; mem_wr = 1'b1;
      #1;
      n_tests++;
      if (outs !== exp_o[c] || state !== exp_s[c]) begin
        n_fail++;
        $display("FAIL branch c%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 c, outs, state, exp_o[c], exp_s[c]);
      end
      @(negedge clk);
      set_idle();
    end
  endtask

  task automatic test_memwait_redir();
    logic [4:0] exp_o [7];
    logic [1:0] exp_s [7];
    exp_o = '{5'b00111, 5'b11000, 5'b11000, 5'b11000, 5'b0, 5'b00100, 5'b0};
    exp_s = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      ex_ce = (c == 0); ex_br = (c == 0);
      dreq = (c >= 1 && c <= 4); dack = (c == 4);
      #1;
      n_tests++;
      if (outs !== exp_o[c] || state !== exp_s[c]) begin
        n_fail++;
        $display("FAIL memwait_redir c%0d: got outs=%b state=%0d expected outs=%b state=%0d",
                 c, outs, state, exp_o[c], exp_s[c]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (stall_cycles !== 4'd3) begin
      n_fail++; $display("FAIL memwait_cnt: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_haz();
    do_reset();
    id_ce = 1'b1; use_rs1 = 1'b1; rs1 = 5'd9;
    ex_ce = 1'b1; ex_rd = 5'd9; ex_wr = 1'b1; ex_load = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 2'd1 || outs !== 5'b11010) begin
      n_fail++; $display("FAIL haz_hold: got outs=%b state=%0d expected 11010 1", outs, state);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (outs !== 5'b0 || state !== 2'd0 || stall_cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_haz: got outs=%b state=%0d cnt=%0d expected 0 0 0",
               outs, state, stall_cycles);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL after_reset: got state=%0d cnt=%0d expected 0 0", state, stall_cycles);
    end
  endtask

  task automatic test_random();
    // Model: remaining flush cycles, load-use/RAW hold, frozen-on-memory flag, stall tally.
    int flush_left = 0;
    bit in_haz = 1'b0, in_mem = 1'b0;
    int stalls = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] exp_o;
      logic [1:0] exp_s;
      int         exp_cnt;
      bit         hz, mw, br;
      reset   = ($urandom_range(0, 99) < 2);
      id_ce   = ($urandom_range(0, 3) != 0);
      use_rs1 = 1'($urandom_range(0, 1));
      use_rs2 = 1'($urandom_range(0, 1));
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      ex_ce   = ($urandom_range(0, 3) != 0);
      ex_rd   = 5'($urandom_range(0, 3));
      ex_wr   = ($urandom_range(0, 3) != 0);
      ex_load = 1'($urandom_range(0, 1));
      ex_br   = ($urandom_range(0, 9) == 0);
      mem_ce  = ($urandom_range(0, 3) != 0);
      mem_rd  = 5'($urandom_range(0, 3));
      mem_wr  = ($urandom_range(0, 3) != 0);
      dreq    = ($urandom_range(0, 5) == 0);
      dack    = 1'($urandom_range(0, 1));
      hz = model_hazard();
      mw = dreq && !dack;
      br = ex_ce && ex_br;
      exp_o   = 5'b0;
      exp_s   = in_mem ? 2'd2 : (flush_left > 0) ? 2'd3 : in_haz ? 2'd1 : 2'd0;
      exp_cnt = stalls;
      if (reset) begin
        exp_s = 2'd0; exp_cnt = 0;
        flush_left = 0; in_haz = 1'b0; in_mem = 1'b0; stalls = 0;
      end else if (mw) begin
        exp_o = 5'b11000; in_mem = 1'b1; in_haz = 1'b0;
      end else if (in_mem) begin
        in_mem = 1'b0;
      end else if (flush_left > 0) begin
        exp_o = 5'b00100; flush_left--;
      end else if (br) begin
        exp_o = 5'b00111; flush_left = FLUSH_CYCLES - 1; in_haz = 1'b0;
      end else begin
        in_haz = hz;
        if (hz) exp_o = 5'b11010;
      end
      if (exp_o[3] && stalls < CNT_MAX) stalls++;
      #1;
      n_tests++;
      if (outs !== exp_o) begin
        n_fail++; $display("FAIL rand_outs c%0d: got %b expected %b", c, outs, exp_o);
      end
      n_tests++;
      if (state !== exp_s) begin
        n_fail++; $display("FAIL rand_state c%0d: got %0d expected %0d", c, state, exp_s);
      end
      n_tests++;
      if (int'(stall_cycles) !== exp_cnt) begin
        n_fail++; $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, stall_cycles, exp_cnt);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_raw_rs2();
    test_no_hazard();
    test_branch();
    test_memwait_redir();
    test_reset_mid_haz();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
